// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch request handshake between the PC stage and instruction memory.
//   fetchValid : request valid (driven by the fetch stage)
//   fetchPC    : word-aligned fetch address (driven by the fetch stage)
//   fetchReady : memory accepts the current request (driven by the memory side)
interface pc_fetch_unit_if;
    logic        fetchValid;
    logic        fetchReady;
    logic [63:0] fetchPC;

    modport master (
        output fetchValid,
        output fetchPC,
        input  fetchReady
    );

    modport slave (
        input  fetchValid,
        input  fetchPC,
        output fetchReady
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// LEGv8 program-counter / fetch-request stage.
// Holds the architectural PC, issues fetch requests over valid/ready and
// redirects to branchPC + (signExtImm << 2) on a taken branch, pulsing flush.
// Ports:
//   CLOCK, nRESET    : rising-edge clock, asynchronous active-low reset
//   branchTaken      : combined taken decision from the branch OR gate
//   branchPC         : address of the resolving branch
//   signExtImm       : sign-extended word offset
//   fetch            : fetch request handshake (master side)
//   flush            : one-cycle squash pulse per sampled taken branch
//   redirectPending  : a branch target is waiting behind a stalled request
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                CLOCK,
    input  logic                nRESET,
    input  logic                branchTaken,
    input  logic [63:0]         branchPC,
    input  logic [63:0]         signExtImm,
    pc_fetch_unit_if.master     fetch,
    output logic                flush,
    output logic                redirectPending
);

    localparam int unsigned ADDR_W = 64;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic               valid_q, valid_d;
    logic               flush_q, flush_d;
    logic               pend_q, pend_d;

    logic [ADDR_W-1:0]  target;
    logic               accept;

    // Branch target, wrapping mod 2^64 and forced onto a word boundary.
    assign target = (branchPC + (signExtImm << 2)) & WORD_MASK;
    assign accept = valid_q & fetch.fetchReady;

    // State register.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (branchTaken && !accept) state_d = HOLD;
            HOLD:    if (accept) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Next values for PC, stored target and the registered outputs.
    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        flush_d = branchTaken;
        valid_d = (state_d != IDLE);
        pend_d  = (state_d == HOLD);
        case (state_q)
            IDLE: begin
                if (branchTaken) pc_d = target;
            end
            FETCH: begin
                if (branchTaken) begin
                    // A stalled request must stay stable, so park the target.
                    if (accept) pc_d = target;
                    else        tgt_d = target;
                end else if (accept) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            HOLD: begin
                // Newest taken branch overrides any parked target.
                if (branchTaken) tgt_d = target;
                if (accept)      pc_d  = branchTaken ? target : tgt_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            pc_q    <= RESET_PC & WORD_MASK;
            tgt_q   <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            pend_q  <= pend_d;
        end
    end

    assign fetch.fetchValid = valid_q;
    assign fetch.fetchPC    = pc_q;
    assign flush            = flush_q;
    assign redirectPending  = pend_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: expected accepted fetch addresses are
// queued as stimulus is driven; a monitor records real accepts for comparison.
module tb_pc_fetch_unit;

    logic        CLOCK;
    logic        nRESET;
    logic        branchTaken;
    logic [63:0] branchPC;
    logic [63:0] signExtImm;
    logic        flush;
    logic        redirectPending;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(64'h0)) dut (
        .CLOCK           (CLOCK),
        .nRESET          (nRESET),
        .branchTaken     (branchTaken),
        .branchPC        (branchPC),
        .signExtImm      (signExtImm),
        .fetch           (bus),
        .flush           (flush),
        .redirectPending (redirectPending)
    );

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Record every request the memory side actually accepts.
    always @(posedge CLOCK) begin
        if (nRESET && bus.fetchValid && bus.fetchReady) got_q.push_back(bus.fetchPC);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Apply and release reset; returns at a falling edge with fetchReady=1.
    task automatic do_reset();
        @(negedge CLOCK);
        nRESET = 1'b0; branchTaken = 1'b0; bus.fetchReady = 1'b0;
        branchPC = '0; signExtImm = '0;
        @(negedge CLOCK);
        nRESET = 1'b1; bus.fetchReady = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset();
        logic [63:0] e, g;
        nRESET = 1'b0; branchTaken = 1'b0; bus.fetchReady = 1'b1;
        branchPC = '0; signExtImm = '0;
        #12;
        total++; if (bus.fetchValid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.fetchValid); else passed++;
        total++; if (bus.fetchPC !== 64'h0) $display("FAIL rst_pc: got %h want 0", bus.fetchPC); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL rst_flush: got %0b want 0", flush); else passed++;
        total++; if (redirectPending !== 1'b0) $display("FAIL rst_pend: got %0b want 0", redirectPending); else passed++;
        @(negedge CLOCK);
        nRESET = 1'b1;
        total++; if (bus.fetchValid !== 1'b0) $display("FAIL rst_first_idle: got %0b want 0", bus.fetchValid); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK);
            total++; if (bus.fetchPC !== 64'(4 * k)) $display("FAIL seq_pc%0d: got %h want %h", k, bus.fetchPC, 64'(4 * k)); else passed++;
            total++; if (bus.fetchValid !== 1'b1) $display("FAIL seq_valid%0d: got %0b want 1", k, bus.fetchValid); else passed++;
            total++; if (flush !== 1'b0 || redirectPending !== 1'b0) $display("FAIL seq_quiet%0d: got flush=%0b pend=%0b want 0 0", k, flush, redirectPending); else passed++;
            if (k < 3) exp_q.push_back(64'(4 * k));
            else bus.fetchReady = 1'b0;
        end
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'hC) $display("FAIL seq_freeze: got %h want c", bus.fetchPC); else passed++;
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL seq_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL seq_sb: got %h want %h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK); exp_q.push_back(64'h0);
        @(negedge CLOCK); exp_q.push_back(64'h4);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h8) $display("FAIL bp_start: got %h want 8", bus.fetchPC); else passed++;
        bus.fetchReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK);
            total++; if (bus.fetchPC !== 64'h8 || bus.fetchValid !== 1'b1) $display("FAIL bp_hold%0d: got pc=%h valid=%0b want 8 1", k, bus.fetchPC, bus.fetchValid); else passed++;
        end
        bus.fetchReady = 1'b1; exp_q.push_back(64'h8);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'hC) $display("FAIL bp_advance: got %h want c", bus.fetchPC); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL bp_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    task automatic test_branch_accept();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK); exp_q.push_back(64'h0);
        @(negedge CLOCK); exp_q.push_back(64'h4);
        @(negedge CLOCK);
        branchTaken = 1'b1; branchPC = 64'h10; signExtImm = 64'h4; exp_q.push_back(64'h8);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h20) $display("FAIL br_pc: got %h want 20", bus.fetchPC); else passed++;
        total++; if (flush !== 1'b1) $display("FAIL br_flush: got %0b want 1", flush); else passed++;
        total++; if (redirectPending !== 1'b0) $display("FAIL br_pend: got %0b want 0", redirectPending); else passed++;
        branchTaken = 1'b0; exp_q.push_back(64'h20);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h24) $display("FAIL br_next: got %h want 24", bus.fetchPC); else passed++;
        total++; if (flush !== 1'b0) $display("FAIL br_flush_end: got %0b want 0", flush); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL br_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL br_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    task automatic test_hold_newest();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK);
        branchTaken = 1'b1; branchPC = 64'h0; signExtImm = 64'hC; exp_q.push_back(64'h0);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h30) $display("FAIL hold_setup: got %h want 30", bus.fetchPC); else passed++;
        branchTaken = 1'b0; bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (flush !== 1'b0 || redirectPending !== 1'b0) $display("FAIL hold_pre: got flush=%0b pend=%0b want 0 0", flush, redirectPending); else passed++;
        branchTaken = 1'b1; signExtImm = 64'h10;
        @(negedge CLOCK);
        total++; if (redirectPending !== 1'b1 || flush !== 1'b1) $display("FAIL hold_br1: got pend=%0b flush=%0b want 1 1", redirectPending, flush); else passed++;
        total++; if (bus.fetchPC !== 64'h30 || bus.fetchValid !== 1'b1) $display("FAIL hold_pc1: got pc=%h valid=%0b want 30 1", bus.fetchPC, bus.fetchValid); else passed++;
        signExtImm = 64'h20;
        @(negedge CLOCK);
        total++; if (redirectPending !== 1'b1 || flush !== 1'b1) $display("FAIL hold_br2: got pend=%0b flush=%0b want 1 1", redirectPending, flush); else passed++;
        total++; if (bus.fetchPC !== 64'h30) $display("FAIL hold_pc2: got %h want 30", bus.fetchPC); else passed++;
        branchTaken = 1'b0;
        @(negedge CLOCK);
        total++; if (redirectPending !== 1'b1 || flush !== 1'b0) $display("FAIL hold_wait: got pend=%0b flush=%0b want 1 0", redirectPending, flush); else passed++;
        total++; if (bus.fetchPC !== 64'h30) $display("FAIL hold_pc3: got %h want 30", bus.fetchPC); else passed++;
        bus.fetchReady = 1'b1; exp_q.push_back(64'h30);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h80) $display("FAIL hold_target: got %h want 80", bus.fetchPC); else passed++;
        total++; if (redirectPending !== 1'b0) $display("FAIL hold_pend_clr: got %0b want 0", redirectPending); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL hold_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL hold_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    task automatic test_neg_wrap();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK);
        branchTaken = 1'b1; branchPC = 64'h8; signExtImm = 64'hFFFF_FFFF_FFFF_FFFC; exp_q.push_back(64'h0);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wrap_target: got %h want fffffffffffffff8", bus.fetchPC); else passed++;
        branchTaken = 1'b0; exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_next: got %h want fffffffffffffffc", bus.fetchPC); else passed++;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h0) $display("FAIL wrap_zero: got %h want 0", bus.fetchPC); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL wrap_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK);
        branchTaken = 1'b1; branchPC = 64'h200; signExtImm = 64'h1; exp_q.push_back(64'h0);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h204 || flush !== 1'b1) $display("FAIL b2b_first: got pc=%h flush=%0b want 204 1", bus.fetchPC, flush); else passed++;
        branchPC = 64'h400; signExtImm = 64'hFFFF_FFFF_FFFF_FFFF; exp_q.push_back(64'h204);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h3FC || flush !== 1'b1) $display("FAIL b2b_second: got pc=%h flush=%0b want 3fc 1", bus.fetchPC, flush); else passed++;
        branchTaken = 1'b0; exp_q.push_back(64'h3FC);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h400 || flush !== 1'b0) $display("FAIL b2b_after: got pc=%h flush=%0b want 400 0", bus.fetchPC, flush); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL b2b_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [63:0] e, g;
        do_reset();
        @(negedge CLOCK);
        bus.fetchReady = 1'b0; branchTaken = 1'b1; branchPC = 64'h100; signExtImm = 64'h0;
        @(negedge CLOCK);
        total++; if (redirectPending !== 1'b1 || flush !== 1'b1) $display("FAIL mrst_hold: got pend=%0b flush=%0b want 1 1", redirectPending, flush); else passed++;
        branchTaken = 1'b0;
        #2 nRESET = 1'b0;
        #1;
        total++; if (bus.fetchValid !== 1'b0) $display("FAIL mrst_valid: got %0b want 0", bus.fetchValid); else passed++;
        total++; if (bus.fetchPC !== 64'h0) $display("FAIL mrst_pc: got %h want 0", bus.fetchPC); else passed++;
        total++; if (flush !== 1'b0 || redirectPending !== 1'b0) $display("FAIL mrst_quiet: got flush=%0b pend=%0b want 0 0", flush, redirectPending); else passed++;
        @(negedge CLOCK);
        nRESET = 1'b1; bus.fetchReady = 1'b1;
        got_q.delete();
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h0 || bus.fetchValid !== 1'b1) $display("FAIL mrst_restart: got pc=%h valid=%0b want 0 1", bus.fetchPC, bus.fetchValid); else passed++;
        exp_q.push_back(64'h0);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h4) $display("FAIL mrst_no_old: got %h want 4", bus.fetchPC); else passed++;
        exp_q.push_back(64'h4);
        @(negedge CLOCK);
        total++; if (bus.fetchPC !== 64'h8) $display("FAIL mrst_seq: got %h want 8", bus.fetchPC); else passed++;
        bus.fetchReady = 1'b0;
        @(negedge CLOCK);
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL mrst_sb_count: got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) $display("FAIL mrst_sb: got %h want %h", g, e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_branch_accept();
        test_hold_newest();
        test_neg_wrap();
        test_back_to_back();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
